data_memory_ctrl: RTL and testbench
===================================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DATA_W, default 19, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of words.
REQ-003 Parameter ADDR_W, default 8, SHALL set the address width; DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 2, legal 1..4, SHALL set read latency in cycles.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 WR_EN_DM  in  1  SHALL be the write request, sampled each edge.
REQ-008 RD_EN_DM  in  1  SHALL be the read request, sampled each edge.
REQ-009 address  in  ADDR_W  SHALL be the word address for the request.
REQ-010 data_in  in  DATA_W  SHALL be the write data.
REQ-011 data_out  out  DATA_W  SHALL be the registered read data, held until the next read completes.
REQ-012 rd_valid  out  1  SHALL pulse high for exactly one cycle when data_out is updated.
REQ-013 busy  out  1  SHALL be high while a read is in flight.
REQ-014 addr_err  out  1  SHALL pulse high one cycle for an out-of-range access.
REQ-015 par_err  out  1  SHALL flag a parity mismatch on a completed read.

Function
REQ-016 FSM states IDLE, READ, DONE; reset state IDLE.
REQ-017 IDLE + RD_EN_DM SHALL capture address, load latency counter with RD_LAT-1, go READ (or DONE if RD_LAT=1), assert busy.
REQ-018 READ SHALL decrement the counter each cycle; at zero go DONE.
REQ-019 DONE SHALL register array word into data_out, pulse rd_valid, drop busy, return IDLE; rd_valid appears exactly RD_LAT cycles after the accepting edge.
REQ-020 RD_EN_DM while busy SHALL be ignored with no response.
REQ-021 WR_EN_DM SHALL be accepted in every state and commit data_in at that edge.
REQ-022 Read data SHALL be write-first: a write to the in-flight address at or before the DONE edge is returned.
REQ-023 WR_EN_DM and RD_EN_DM same cycle, same address: write commits, read returns new data.
REQ-024 address >= DEPTH: write dropped, addr_err pulses next cycle; read completes normally with data_out=0 and addr_err pulsed with rd_valid.
REQ-025 Address arithmetic SHALL be unsigned, no wrap; out-of-range never aliases.

Reset
REQ-026 rst_n low SHALL force IDLE, counter 0, data_out 0, rd_valid 0, busy 0, addr_err 0, par_err 0.
REQ-027 Reset mid-read SHALL abort the read; no rd_valid after release.
REQ-028 Array contents SHALL not be reset.

Configuration
REQ-029 Macro DMEM_PARITY_EN defined: each word stores one extra even-parity bit; par_err pulses with rd_valid on mismatch.
REQ-030 Macro undefined: no parity bit stored, par_err tied 0.

Structure
REQ-031 Package constants SHALL hold default DATA_W/DEPTH/ADDR_W/RD_LAT and the FSM state enum dmem_state_t.
REQ-032 Storage SHALL be a sub-module dmem_array (single write port, single async read port, width DATA_W or DATA_W+1).

Verification
REQ-033 RD_LAT=2: write 19'h12345 @10, then read @10 -> rd_valid one cycle, 2 cycles after accept, data_out=19'h12345, busy high 2 cycles.
REQ-034 Write 19'h1A2B3 @20 same cycle as read @20 -> data_out=19'h1A2B3.
REQ-035 Read @10 in flight, write 19'h00001 @10 next cycle -> data_out=19'h00001; second RD_EN_DM while busy -> no extra rd_valid.
REQ-036 DEPTH=200: write @210 -> addr_err pulse, no store; read @210 -> data_out=0, addr_err with rd_valid.
REQ-037 Assert rst_n low one cycle after read accept -> no rd_valid, all outputs 0, busy 0.
REQ-038 DMEM_PARITY_EN: force parity bit of @10 flipped, read @10 -> par_err=1 with rd_valid; without macro par_err stays 0.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl_pkg
//   Default geometry and the read-FSM state type for data_memory_ctrl.
//   Optional feature macro used by the design: DMEM_PARITY_EN.
// ---------------------------------------------------------------------------
package data_memory_ctrl_pkg;

    localparam int DMEM_DATA_W = 19;   // data word width
    localparam int DMEM_DEPTH  = 256;  // number of words
    localparam int DMEM_ADDR_W = 8;    // address width, DEPTH <= 2**ADDR_W
    localparam int DMEM_RD_LAT = 2;    // read latency in cycles, 1..4

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } dmem_state_t;

endpackage : data_memory_ctrl_pkg

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
//   Word storage: one synchronous write port, one asynchronous read port.
//   Ports:
//     clk      in  clock
//     wr_en    in  write strobe (already qualified by the caller)
//     wr_addr  in  write word address
//     wr_data  in  write word
//     rd_addr  in  read word address
//     rd_data  out word at rd_addr (combinational)
//   WIDTH is DATA_W, or DATA_W+1 when DMEM_PARITY_EN adds a parity bit.
// ---------------------------------------------------------------------------
module dmem_array #(
    parameter int WIDTH  = 19,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; clearing every word would turn the array
    // into flops with a reset tree instead of a plain memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : dmem_array

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//   Single-port data memory with a fixed-latency read FSM (IDLE/READ/DONE),
//   write-first read data, out-of-range detection and optional even parity.
//   Optional feature macro: DMEM_PARITY_EN (stores a parity bit per word and
//   reports mismatches on par_err; when undefined par_err stays 0).
//   Ports:
//     clk       in  clock, rising edge
//     rst_n     in  asynchronous active-low reset
//     WR_EN_DM  in  write request, accepted in every state
//     RD_EN_DM  in  read request, accepted only while idle
//     address   in  word address for either request
//     data_in   in  write data
//     data_out  out registered read data, held until the next read completes
//     rd_valid  out one-cycle pulse when data_out updates
//     busy      out high while a read is in flight
//     addr_err  out one-cycle pulse for an out-of-range access
//     par_err   out parity mismatch, pulses with rd_valid
// ---------------------------------------------------------------------------
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int RD_LAT = DMEM_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WR_EN_DM,
    input  logic              RD_EN_DM,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err,
    output logic              par_err
);

`ifdef DMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam int                CNT_W     = 2;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RD_LAT - 1);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    dmem_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] rd_addr;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              mem_wr_en;
    logic              fwd_hit;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic [DATA_W-1:0] done_data;
    logic              done_par_bad;

    // Unsigned range checks; out-of-range addresses are never folded back
    // into the array.
    assign wr_in_range = {1'b0, address} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
    assign mem_wr_en   = WR_EN_DM && wr_in_range;

    // A write landing on the in-flight address at the DONE edge commits to
    // the array on that same edge, so its data is forwarded to data_out.
    assign fwd_hit     = mem_wr_en && (address == rd_addr);

`ifdef DMEM_PARITY_EN
    // Even parity: stored bit makes the total number of ones even.
    assign wr_word      = {^data_in, data_in};
    assign done_par_bad = !fwd_hit && (^rd_word);
`else
    assign wr_word      = data_in;
    assign done_par_bad = 1'b0;
`endif

    assign done_data = fwd_hit ? data_in : rd_word[DATA_W-1:0];

    dmem_array #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (address),
        .wr_data (wr_word),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    assign busy = (state != S_IDLE);

    // NOTE: every register here uses <= so all flops sample pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_addr  <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            par_err  <= 1'b0;
            // Dropped out-of-range write is reported in the following cycle.
            addr_err <= WR_EN_DM && !wr_in_range;

            case (state)
                S_IDLE: begin
                    if (RD_EN_DM) begin
                        rd_addr <= address;
                        cnt     <= CNT_LOAD;
                        state   <= (RD_LAT == 1) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    cnt <= cnt - 1'b1;
                    // Counter reaching zero on this edge moves to DONE.
                    if (cnt <= CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    rd_valid <= 1'b1;
                    state    <= S_IDLE;
                    if (rd_in_range) begin
                        data_out <= done_data;
                        par_err  <= done_par_bad;
                    end else begin
                        data_out <= '0;
                        addr_err <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule : data_memory_ctrl

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//   Self-checking bench for data_memory_ctrl (DEPTH=200, RD_LAT=2), with a
//   transaction-level reference: a word array plus one pending-read record
//   that completes RD_LAT edges after acceptance. Directed scenarios first,
//   then randomized traffic. Honours DMEM_PARITY_EN for the parity case.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

    localparam int DATA_W = 19;
    localparam int DEPTH  = 200;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              addr_err;
    logic              par_err;

    data_memory_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .WR_EN_DM (wr_en),
        .RD_EN_DM (rd_en),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .busy     (busy),
        .addr_err (addr_err),
        .par_err  (par_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [256];
    bit                bad_par [256];
    bit                pend;
    int                pend_left;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] exp_data;
    bit                exp_rd_valid;
    bit                exp_busy;
    bit                exp_addr_err;
    bit                exp_par_err;

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_data));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_rd_valid));
        check({tag, ".busy"},     32'(busy),     32'(exp_busy));
        check({tag, ".addr_err"}, 32'(addr_err), 32'(exp_addr_err));
        check({tag, ".par_err"},  32'(par_err),  32'(exp_par_err));
    endtask

    // Drive one cycle of requests, advance one edge, update the model and
    // compare every output 1 time unit after the edge.
    task automatic cycle(input bit wr, input bit rd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        bit was_pend;
        wr_en   = wr;
        rd_en   = rd;
        address = a;
        data_in = d;
        @(posedge clk);
        was_pend     = pend;
        exp_rd_valid = 1'b0;
        exp_addr_err = 1'b0;
        exp_par_err  = 1'b0;
        if (was_pend) pend_left--;
        else if (rd) begin
            pend      = 1'b1;
            pend_left = RD_LAT;
            pend_addr = a;
        end
        // Writes land before a same-edge completion is resolved (write-first).
        if (wr) begin
            if (int'(a) < DEPTH) begin
                ref_mem[a] = d;
                bad_par[a] = 1'b0;
            end else begin
                exp_addr_err = 1'b1;
            end
        end
        if (was_pend && pend_left == 0) begin
            pend         = 1'b0;
            exp_rd_valid = 1'b1;
            if (int'(pend_addr) < DEPTH) begin
                exp_data    = ref_mem[pend_addr];
                exp_par_err = bad_par[pend_addr];
            end else begin
                exp_data     = '0;
                exp_addr_err = 1'b1;
            end
        end
        exp_busy = pend;
        #1;
        check_outputs("cyc");
    endtask

    task automatic apply_reset();
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        rst_n        = 1'b0;
        pend         = 1'b0;
        pend_left    = 0;
        exp_data     = '0;
        exp_rd_valid = 1'b0;
        exp_busy     = 1'b0;
        exp_addr_err = 1'b0;
        exp_par_err  = 1'b0;
        #1;
        check_outputs("rst");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                wr;
        bit                rd;

        vectors     = 0;
        miscompares = 0;
        #2;
        apply_reset();

        // Give every in-range word a known value.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, ADDR_W'(i), DATA_W'($urandom));
        end

        // Write then read @10: two busy cycles, rd_valid two edges after accept.
        cycle(1'b1, 1'b0, 8'd10, 19'h12345);
        cycle(1'b0, 1'b1, 8'd10, '0);
        check("r_lat.busy1", 32'(busy), 32'd1);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("r_lat.busy2", 32'(busy), 32'd1);
        check("r_lat.early", 32'(rd_valid), 32'd0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("r_lat.valid", 32'(rd_valid), 32'd1);
        check("r_lat.data", 32'(data_out), 32'h12345);
        check("r_lat.idle", 32'(busy), 32'd0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("r_lat.pulse", 32'(rd_valid), 32'd0);

        // Same-cycle write and read to @20 returns the new data.
        cycle(1'b1, 1'b1, 8'd20, 19'h1A2B3);
        cycle(1'b0, 1'b0, 8'd0, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("wr_rd_same.data", 32'(data_out), 32'h1A2B3);

        // Write to the in-flight address; second read while busy is ignored.
        cycle(1'b0, 1'b1, 8'd10, '0);
        cycle(1'b1, 1'b1, 8'd10, 19'h00001);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("inflight_wr.data", 32'(data_out), 32'h00001);
        check("inflight_wr.valid", 32'(rd_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'd0, '0);
            check("busy_rd.no_extra", 32'(rd_valid), 32'd0);
        end

        // Write at the DONE edge itself is returned.
        cycle(1'b0, 1'b1, 8'd30, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        cycle(1'b1, 1'b0, 8'd30, 19'h5A5A5);
        check("done_edge_wr.data", 32'(data_out), 32'h5A5A5);

        // Out-of-range write: dropped, addr_err next cycle; read returns 0.
        cycle(1'b1, 1'b0, 8'd210, 19'h7FFFF);
        check("oor_wr.err", 32'(addr_err), 32'd1);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("oor_wr.err_pulse", 32'(addr_err), 32'd0);
        cycle(1'b0, 1'b1, 8'd210, '0);
        check("oor_rd.no_err_yet", 32'(addr_err), 32'd0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("oor_rd.valid", 32'(rd_valid), 32'd1);
        check("oor_rd.data", 32'(data_out), 32'd0);
        check("oor_rd.err", 32'(addr_err), 32'd1);
        // Highest legal word and the aliasing candidate (210 - 200) unchanged.
        cycle(1'b0, 1'b1, 8'd199, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        cycle(1'b0, 1'b1, 8'd10, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("no_alias.data", 32'(data_out), 32'h00001);

        // Reset one cycle after a read is accepted aborts it.
        cycle(1'b0, 1'b1, 8'd20, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 8'd0, '0);
            check("rst_abort.no_valid", 32'(rd_valid), 32'd0);
        end

`ifdef DMEM_PARITY_EN
        u_dut.u_array.mem[10][DATA_W] = ~u_dut.u_array.mem[10][DATA_W];
        bad_par[10] = 1'b1;
        cycle(1'b0, 1'b1, 8'd10, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("parity.err", 32'(par_err), 32'd1);
`else
        cycle(1'b0, 1'b1, 8'd10, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        cycle(1'b0, 1'b0, 8'd0, '0);
        check("parity.off", 32'(par_err), 32'd0);
`endif

        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            wr = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 2) == 0);
            a  = ADDR_W'($urandom_range(0, 219));
            if (pend && $urandom_range(0, 3) == 0) a = pend_addr;
            d  = DATA_W'($urandom);
            cycle(wr, rd, a, d);
            if (i == 700) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_data_memory_ctrl
